// File: rtl/grover_pkg.sv
// Shared types and constants for the Grover search sequencer.
// FSM state enum, bank size, index width and saturation limit.
package grover_pkg;

  localparam int N_AMP = 8;
  localparam int IDX_W = 3;

  // Result of negating the most negative 8-bit amplitude.
  localparam logic [7:0] NEG_SAT = 8'h7f;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ORACLE,
    S_DIFFUSE,
    S_SCAN,
    S_DONE
  } state_t;

endpackage

// File: rtl/grover_sequencer_invert_mean.sv
// Combinational inversion about the mean for eight amplitudes.
// Ports: i0..i7 amplitudes in, o0..o7 = 2*floor(sum/8) - i_k out.
module invert_mean #(
  parameter int AMP_W = 8
) (
  input  logic signed [AMP_W-1:0] i0,
  input  logic signed [AMP_W-1:0] i1,
  input  logic signed [AMP_W-1:0] i2,
  input  logic signed [AMP_W-1:0] i3,
  input  logic signed [AMP_W-1:0] i4,
  input  logic signed [AMP_W-1:0] i5,
  input  logic signed [AMP_W-1:0] i6,
  input  logic signed [AMP_W-1:0] i7,
  output logic signed [AMP_W-1:0] o0,
  output logic signed [AMP_W-1:0] o1,
  output logic signed [AMP_W-1:0] o2,
  output logic signed [AMP_W-1:0] o3,
  output logic signed [AMP_W-1:0] o4,
  output logic signed [AMP_W-1:0] o5,
  output logic signed [AMP_W-1:0] o6,
  output logic signed [AMP_W-1:0] o7
);

  localparam int SW = AMP_W + 3;

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] mean2;

  assign sum = SW'(i0) + SW'(i1) + SW'(i2) + SW'(i3)
             + SW'(i4) + SW'(i5) + SW'(i6) + SW'(i7);

  // Arithmetic shift gives floor division, then doubled.
  assign mean2 = (sum >>> 3) <<< 1;

  assign o0 = AMP_W'(mean2 - SW'(i0));
  assign o1 = AMP_W'(mean2 - SW'(i1));
  assign o2 = AMP_W'(mean2 - SW'(i2));
  assign o3 = AMP_W'(mean2 - SW'(i3));
  assign o4 = AMP_W'(mean2 - SW'(i4));
  assign o5 = AMP_W'(mean2 - SW'(i5));
  assign o6 = AMP_W'(mean2 - SW'(i6));
  assign o7 = AMP_W'(mean2 - SW'(i7));

endmodule

// File: rtl/grover_sequencer.sv
// Grover search sequencer: init, oracle/diffuse iterations, argmax scan.
// Ports: clk, rst (sync high), start/target/iter request, busy, done,
// best_idx result, amp0..amp7 bank; optional step (GROVER_SEQ_STEP_EN).
module grover_sequencer
  import grover_pkg::*;
#(
  parameter logic signed [7:0] INIT_AMP = 8'sd32,
  parameter int                AMP_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2:0]              target,
  input  logic [3:0]              iter,
`ifdef GROVER_SEQ_STEP_EN
  input  logic                    step,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              best_idx,
  output logic signed [AMP_W-1:0] amp0,
  output logic signed [AMP_W-1:0] amp1,
  output logic signed [AMP_W-1:0] amp2,
  output logic signed [AMP_W-1:0] amp3,
  output logic signed [AMP_W-1:0] amp4,
  output logic signed [AMP_W-1:0] amp5,
  output logic signed [AMP_W-1:0] amp6,
  output logic signed [AMP_W-1:0] amp7
);

  localparam logic signed [AMP_W-1:0] AMP_MIN =
    {1'b1, {(AMP_W-1){1'b0}}};
  localparam logic signed [AMP_W-1:0] AMP_MAX =
    (AMP_W == 8) ? AMP_W'(NEG_SAT)
                 : {1'b0, {(AMP_W-1){1'b1}}};
  localparam logic signed [AMP_W-1:0] AMP_INIT =
    AMP_W'(INIT_AMP);

  state_t state, state_nx;

  logic [IDX_W-1:0]        tgt_q;
  logic [IDX_W-1:0]        scan_idx;
  logic [IDX_W-1:0]        best_q;
  logic [3:0]              iter_q;
  logic [3:0]              cnt_q;
  logic signed [AMP_W-1:0] amp_q [N_AMP];
  logic signed [AMP_W-1:0] inv   [N_AMP];
  logic signed [AMP_W-1:0] best_amp;
  logic signed [AMP_W-1:0] tgt_amp;
  logic signed [AMP_W-1:0] tgt_neg;
  logic signed [AMP_W-1:0] scan_amp;
  logic                    adv;

`ifdef GROVER_SEQ_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  invert_mean #(.AMP_W(AMP_W)) u_invert_mean (
    .i0(amp_q[0]), .i1(amp_q[1]), .i2(amp_q[2]), .i3(amp_q[3]),
    .i4(amp_q[4]), .i5(amp_q[5]), .i6(amp_q[6]), .i7(amp_q[7]),
    .o0(inv[0]),   .o1(inv[1]),   .o2(inv[2]),   .o3(inv[3]),
    .o4(inv[4]),   .o5(inv[5]),   .o6(inv[6]),   .o7(inv[7])
  );

  // Negating the most negative value would wrap; clamp it instead.
  assign tgt_amp  = amp_q[tgt_q];
  assign tgt_neg  = (tgt_amp == AMP_MIN) ? AMP_MAX : -tgt_amp;
  assign scan_amp = amp_q[scan_idx];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (start) state_nx = S_INIT;
      S_INIT:    state_nx = (iter_q != 4'd0) ? S_ORACLE : S_SCAN;
      S_ORACLE:  if (adv) state_nx = S_DIFFUSE;
      S_DIFFUSE: if (adv)
                   state_nx = (cnt_q == 4'd1) ? S_SCAN : S_ORACLE;
      S_SCAN:    if (scan_idx == IDX_W'(N_AMP-1)) state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q    <= '0;
      iter_q   <= '0;
      cnt_q    <= '0;
      scan_idx <= '0;
      best_q   <= '0;
      best_amp <= '0;
      for (int k = 0; k < N_AMP; k++) amp_q[k] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            tgt_q  <= target;
            iter_q <= iter;
          end
        end
        S_INIT: begin
          cnt_q    <= iter_q;
          scan_idx <= '0;
          for (int k = 0; k < N_AMP; k++) amp_q[k] <= AMP_INIT;
        end
        S_ORACLE: begin
          if (adv) amp_q[tgt_q] <= tgt_neg;
        end
        S_DIFFUSE: begin
          if (adv) begin
            cnt_q <= cnt_q - 4'd1;
            for (int k = 0; k < N_AMP; k++) amp_q[k] <= inv[k];
          end
        end
        S_SCAN: begin
          scan_idx <= scan_idx + 1'b1;
          // Strict compare keeps the lowest index on ties.
          if (scan_idx == '0 || scan_amp > best_amp) begin
            best_amp <= scan_amp;
            best_q   <= scan_idx;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_INIT) || (state == S_ORACLE)
             || (state == S_DIFFUSE) || (state == S_SCAN);
  assign done = (state == S_DONE);
  assign best_idx = best_q;

  assign amp0 = amp_q[0];
  assign amp1 = amp_q[1];
  assign amp2 = amp_q[2];
  assign amp3 = amp_q[3];
  assign amp4 = amp_q[4];
  assign amp5 = amp_q[5];
  assign amp6 = amp_q[6];
  assign amp7 = amp_q[7];

endmodule

// File: tb/tb_grover_sequencer.sv
// Self-checking bench for grover_sequencer against an arithmetic model.
// Define GROVER_SEQ_STEP_EN to exercise the step-stall variant.
module tb_grover_sequencer;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [2:0]        target = '0;
  logic [3:0]        iter = '0;
  logic              step = 1'b1;
  logic              busy, done;
  logic [2:0]        best_idx;
  logic signed [7:0] amp [8];

  int n_checks = 0;
  int n_fail   = 0;
  bit stall_mode = 1'b0;

  always #5 clk = ~clk;

  grover_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .target(target), .iter(iter),
`ifdef GROVER_SEQ_STEP_EN
    .step(step),
`endif
    .busy(busy), .done(done), .best_idx(best_idx),
    .amp0(amp[0]), .amp1(amp[1]), .amp2(amp[2]), .amp3(amp[3]),
    .amp4(amp[4]), .amp5(amp[5]), .amp6(amp[6]), .amp7(amp[7])
  );

  function automatic int wrap8(input int v);
    logic signed [7:0] t;
    t = v[7:0];
    return int'(t);
  endfunction

  function automatic void model(input int tgt, input int it,
                                output int a[8], output int best);
    int s, m;
    for (int k = 0; k < 8; k++) a[k] = 32;
    for (int r = 0; r < it; r++) begin
      a[tgt] = -a[tgt];
      if (a[tgt] > 127) a[tgt] = 127;
      s = 0;
      for (int k = 0; k < 8; k++) s += a[k];
      m = s / 8;
      if (s < 0 && (s % 8) != 0) m = m - 1;
      for (int k = 0; k < 8; k++) a[k] = wrap8(2 * m - a[k]);
    end
    best = 0;
    for (int k = 1; k < 8; k++) if (a[k] > a[best]) best = k;
  endfunction

  // Edge e (0 = edge sampling start) on which each phase executes.
  function automatic int exp_lat(input int it);
    int e;
    if (!stall_mode) return 9 + 2 * it;
    e = 1;
    for (int p = 0; p < 2 * it; p++) begin
      e++;
      while ((e % 3) != 0) e++;
    end
    return e + 8;
  endfunction

  task automatic do_run(input int tgt, input int it, input bit noisy,
                        output int lat, output int busy_bad);
    lat = -1;
    busy_bad = 0;
    @(negedge clk);
    start = 1'b1;
    target = 3'(tgt);
    iter = 4'(it);
    for (int c = 0; c <= 100; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
      if (noisy) begin
        start = 1'b1;
        target = 3'(tgt + 1 + $urandom_range(0, 6));
        iter = 4'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
      step = stall_mode ? (((c + 1) % 3) == 0) : 1'b1;
    end
    if (noisy) begin
      @(negedge clk);
      if (busy) busy_bad++;
    end
    start = 1'b0;
    step = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done);
    end
    n_checks++;
    if (best_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_best got %0d want 0", best_idx);
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (amp[k] !== 8'sd0) begin
        n_fail++;
        $display("FAIL reset_amp%0d got %0d want 0", k, amp[k]);
      end
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_directed;
    int tg [3] = '{3, 5, 5};
    int it [3] = '{0, 1, 2};
    int ea[8];
    int eb, lat, bb;
    for (int i = 0; i < 3; i++) begin
      model(tg[i], it[i], ea, eb);
      do_run(tg[i], it[i], 1'b0, lat, bb);
      n_checks++;
      if (lat !== exp_lat(it[i])) begin
        n_fail++;
        $display("FAIL dir%0d_latency got %0d want %0d",
                 i, lat, exp_lat(it[i]));
      end
      n_checks++;
      if (bb !== 0) begin
        n_fail++;
        $display("FAIL dir%0d_busy bad_cycles=%0d want 0", i, bb);
      end
      n_checks++;
      if (int'(best_idx) !== eb) begin
        n_fail++;
        $display("FAIL dir%0d_best got %0d want %0d", i, best_idx, eb);
      end
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (int'(amp[k]) !== ea[k]) begin
          n_fail++;
          $display("FAIL dir%0d_amp%0d got %0d want %0d",
                   i, k, amp[k], ea[k]);
        end
      end
    end
    n_checks++;
    if (amp[5] !== 8'sd88 || amp[0] !== -8'sd8) begin
      n_fail++;
      $display("FAIL dir_iter2_const amp5=%0d amp0=%0d want 88 -8",
               amp[5], amp[0]);
    end
  endtask

  task automatic test_random;
    int ea[8];
    int eb, lat, bb, tg, it;
    for (int i = 0; i < 20; i++) begin
      tg = $urandom_range(0, 7);
      it = $urandom_range(0, 15);
      model(tg, it, ea, eb);
      do_run(tg, it, 1'b0, lat, bb);
      n_checks++;
      if (lat !== exp_lat(it) || bb !== 0) begin
        n_fail++;
        $display("FAIL rnd%0d_timing lat=%0d busy_bad=%0d want %0d 0",
                 i, lat, bb, exp_lat(it));
      end
      n_checks++;
      if (int'(best_idx) !== eb) begin
        n_fail++;
        $display("FAIL rnd%0d_best t=%0d i=%0d got %0d want %0d",
                 i, tg, it, best_idx, eb);
      end
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (int'(amp[k]) !== ea[k]) begin
          n_fail++;
          $display("FAIL rnd%0d_amp%0d t=%0d i=%0d got %0d want %0d",
                   i, k, tg, it, amp[k], ea[k]);
        end
      end
    end
  endtask

  task automatic test_busy_ignore;
    int ea[8];
    int eb, lat, bb;
    model(2, 3, ea, eb);
    do_run(2, 3, 1'b1, lat, bb);
    n_checks++;
    if (lat !== exp_lat(3) || bb !== 0) begin
      n_fail++;
      $display("FAIL ignore_timing lat=%0d busy_bad=%0d want %0d 0",
               lat, bb, exp_lat(3));
    end
    n_checks++;
    if (int'(best_idx) !== eb) begin
      n_fail++;
      $display("FAIL ignore_best got %0d want %0d", best_idx, eb);
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (int'(amp[k]) !== ea[k]) begin
        n_fail++;
        $display("FAIL ignore_amp%0d got %0d want %0d", k, amp[k], ea[k]);
      end
    end
  endtask

  task automatic test_abort;
    int ea[8];
    int eb, lat, bb, seen;
    @(negedge clk);
    start = 1'b1;
    target = 3'd5;
    iter = 4'd2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 4) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || best_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_flags busy=%b done=%b best=%0d want 0 0 0",
               busy, done, best_idx);
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (amp[k] !== 8'sd0) begin
        n_fail++;
        $display("FAIL abort_amp%0d got %0d want 0", k, amp[k]);
      end
    end
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done active_cycles=%0d want 0", seen);
    end
    model(1, 2, ea, eb);
    do_run(1, 2, 1'b0, lat, bb);
    n_checks++;
    if (lat !== exp_lat(2) || int'(best_idx) !== eb) begin
      n_fail++;
      $display("FAIL abort_restart lat=%0d best=%0d want %0d %0d",
               lat, best_idx, exp_lat(2), eb);
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (int'(amp[k]) !== ea[k]) begin
        n_fail++;
        $display("FAIL abort_restart_amp%0d got %0d want %0d",
                 k, amp[k], ea[k]);
      end
    end
  endtask

`ifdef GROVER_SEQ_STEP_EN
  task automatic test_stall;
    int ea[8];
    int eb, lat, bb;
    stall_mode = 1'b1;
    model(5, 1, ea, eb);
    do_run(5, 1, 1'b0, lat, bb);
    n_checks++;
    if (lat !== exp_lat(1) || lat <= 11) begin
      n_fail++;
      $display("FAIL stall_latency got %0d want %0d", lat, exp_lat(1));
    end
    n_checks++;
    if (int'(best_idx) !== eb) begin
      n_fail++;
      $display("FAIL stall_best got %0d want %0d", best_idx, eb);
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (int'(amp[k]) !== ea[k]) begin
        n_fail++;
        $display("FAIL stall_amp%0d got %0d want %0d", k, amp[k], ea[k]);
      end
    end
    stall_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_abort();
`ifdef GROVER_SEQ_STEP_EN
    test_stall();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
